// File: rtl/uart_rx_core_if.sv
// Bus-side signal bundle for the UART receiver.
//   rx_read   : one-cycle pulse from the bus; consumes the byte, clears status
//   rx_data   : last correctly framed byte
//   rx_valid  : rx_data holds an unread byte
//   frame_err : sticky, a stop bit was sampled low
//   overrun   : sticky, a byte completed while rx_valid was set
//   busy      : receiver is not idle
// master = bus/CPU side, slave = receiver core.
interface uart_rx_core_if;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_read,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    input  rx_read,
    output rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a one-entry receive buffer and sticky error flags.
//   clk     : system clock, rising edge
//   Reset_n : synchronous active-low reset
//   rx_in   : raw serial line, idle high, asynchronous to clk
//   bus     : uart_rx_core_if.slave (rx_read in; rx_data, rx_valid,
//             frame_err, overrun, busy out)
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          rx_in,
  uart_rx_core_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rxs;
  logic                   byte_done;
  logic                   frame_fail;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      sync_q      <= '1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    byte_done   = 1'b0;
    frame_fail  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Half a bit in: re-check the line so short glitches are rejected.
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_fail = 1'b1;
            state_d    = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        // Hold here while the line stays low so a break never yields frames.
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.rx_read) begin
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    // A completing byte beats a simultaneous read; the read still counts as
    // consuming the old byte, so no overrun in that case.
    if (byte_done) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !bus.rx_read) begin
        overrun_d = 1'b1;
      end
    end
    if (frame_fail) begin
      frame_err_d = 1'b1;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core (CLKS_PER_BIT=16, SYNC_STAGES=2).
// Stimulus pushes the expected status tuple {rx_valid, rx_data, frame_err,
// overrun}; the monitor pops and compares each time that tuple changes.
module tb_uart_rx_core;

  localparam int Cpb = 16;
  // Start edge to visible rx_valid: 2 sync + 8 half bit + 9*16 bits + 1.
  localparam int Lat = 2 + Cpb / 2 + 9 * Cpb + 1;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       fe;
    logic       ov;
  } stat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx_in = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;

  stat_t exp_q[$];
  int    exp_cyc_q[$];
  string exp_name_q[$];

  uart_rx_core_if bus ();

  uart_rx_core #(
    .CLKS_PER_BIT(Cpb),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .Reset_n(reset_n),
    .rx_in  (rx_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_stat(input string nm, input logic v, input logic [7:0] d,
                             input logic fe, input logic ov, input int at_cyc);
    stat_t s;
    s.valid = v;
    s.data  = d;
    s.fe    = fe;
    s.ov    = ov;
    exp_q.push_back(s);
    exp_cyc_q.push_back(at_cyc);
    exp_name_q.push_back(nm);
  endtask

  // Called at a negedge; returns at a negedge right after the stop period.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input bit rd,
                            input string nm, input logic ev, input logic [7:0] ed,
                            input logic efe, input logic eov);
    int start;
    start = cyc;
    rx_in = 1'b0;
    expect_stat(nm, ev, ed, efe, eov, start + Lat);
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (Cpb) @(negedge clk);
    end
    for (int j = 0; j < stop_low + Cpb; j++) begin
      rx_in       = (j < stop_low) ? 1'b0 : 1'b1;
      bus.rx_read = rd && (j == 10);
      if (stop_low > 0 && j == stop_low - 1) check({nm, "_break_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    bus.rx_read = 1'b0;
  endtask

  task automatic pulse_read();
    bus.rx_read = 1'b1;
    @(negedge clk);
    bus.rx_read = 1'b0;
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    stat_t prev;
    stat_t cur;
    stat_t e;
    int    ec;
    string nm;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {bus.rx_valid, bus.rx_data, bus.frame_err, bus.overrun};
        if (cur !== prev) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_change: got v=%b d=%h fe=%b ov=%b, expected no change",
                     cur.valid, cur.data, cur.fe, cur.ov);
          end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            nm = exp_name_q.pop_front();
            if (cur !== e || (ec >= 0 && cyc != ec)) begin
              n_errors++;
              $display("FAIL %s: got v=%b d=%h fe=%b ov=%b @%0d, expected v=%b d=%h fe=%b ov=%b @%0d",
                       nm, cur.valid, cur.data, cur.fe, cur.ov, cyc,
                       e.valid, e.data, e.fe, e.ov, ec);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    bus.rx_read = 1'b0;
    // 1. Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // 2. Single frame 0x0C, then read it
    send_frame(8'h0C, 0, 1'b0, "frame_0c", 1'b1, 8'h0C, 1'b0, 1'b0);
    expect_stat("read_0c", 1'b0, 8'h0C, 1'b0, 1'b0, -1);
    pulse_read();

    // 3. Back-to-back without read -> overrun, newest byte kept
    send_frame(8'h0C, 0, 1'b0, "b2b_first", 1'b1, 8'h0C, 1'b0, 1'b0);
    send_frame(8'h08, 0, 1'b0, "b2b_overrun", 1'b1, 8'h08, 1'b0, 1'b1);
    expect_stat("read_overrun", 1'b0, 8'h08, 1'b0, 1'b0, -1);
    pulse_read();

    // 4. 5-clock glitch
    s = cyc;
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    check("glitch_busy_high", 32'(bus.busy), 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_busy_low", 32'(bus.busy), 32'd0);
    check("glitch_valid", 32'(bus.rx_valid), 32'd0);
    check("glitch_frame_err", 32'(bus.frame_err), 32'd0);

    // 5. Framing error with long break, then a good frame
    send_frame(8'hA5, 40, 1'b0, "frame_err_a5", 1'b0, 8'h08, 1'b1, 1'b0);
    send_frame(8'h3C, 0, 1'b0, "after_break_3c", 1'b1, 8'h3C, 1'b1, 1'b0);
    expect_stat("read_3c", 1'b0, 8'h3C, 1'b0, 1'b0, -1);
    pulse_read();

    // 6a. Read in the exact completion cycle while a byte is pending
    send_frame(8'h5A, 0, 1'b0, "frame_5a", 1'b1, 8'h5A, 1'b0, 1'b0);
    send_frame(8'hC3, 0, 1'b1, "read_at_done_c3", 1'b1, 8'hC3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // 6b. Reset during data bit 4 of 0x77
    rx_in = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i == 3) ? 1'b0 : 1'b1;
      repeat (Cpb) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (Cpb / 2) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    expect_stat("mid_frame_reset", 1'b0, 8'h00, 1'b0, 1'b0, -1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    check("post_reset_valid", 32'(bus.rx_valid), 32'd0);
    check("post_reset_data", 32'(bus.rx_data), 32'h00);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
